// File: rtl/voter_session_if.sv
// Handshake bundle between per-voter request logic, the voting session and
// the decision consumer.
interface voter_session_if #(
  parameter int N_VOTERS = 4,
  parameter int CNT_W    = $clog2(N_VOTERS + 1)
);
  logic                start;
  logic                close;
  logic [N_VOTERS-1:0] vote_yes;
  logic [N_VOTERS-1:0] vote_no;
  logic                busy;
  logic                done;
  logic [2:0]          result;
  logic [CNT_W-1:0]    yes_cnt;
  logic [N_VOTERS-1:0] voted;
  logic                timed_out;

  modport master (
    output start, close, vote_yes, vote_no,
    input  busy, done, result, yes_cnt, voted, timed_out
  );

  modport slave (
    input  start, close, vote_yes, vote_no,
    output busy, done, result, yes_cnt, voted, timed_out
  );
endinterface

// File: rtl/voter_session.sv
// Bounded voting session: latches each voter's first vote, closes on
// all-voted / early close / timeout, then publishes a one-hot verdict.
module voter_session #(
  parameter int N_VOTERS = 4,
  parameter int TIMEOUT  = 255,
  parameter int TIMER_W  = 8,
  parameter int CNT_W    = $clog2(N_VOTERS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  voter_session_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, OPEN = 2'd1, RESULT = 2'd2} state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]     N_FULL     = (CNT_W + 1)'(N_VOTERS);

  state_t              state_reg, state_next;
  logic [N_VOTERS-1:0] voted_reg, voted_next;
  logic [CNT_W-1:0]    yes_cnt_reg, yes_cnt_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                timed_out_reg, timed_out_next;
  logic [2:0]          result_reg, result_next;
  logic                done_reg, done_next;

  logic [N_VOTERS-1:0] take_vote;
  logic [N_VOTERS-1:0] take_yes;
  logic [CNT_W-1:0]    new_yes;
  logic [CNT_W:0]      twice_yes;
  logic                all_voted;
  logic                timer_hit;

  // Only a voter's first vote counts; a simultaneous yes+no is a no.
  generate
    for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_voter
      assign take_vote[gi] = ~voted_reg[gi] & (bus.vote_yes[gi] | bus.vote_no[gi]);
      assign take_yes[gi]  = ~voted_reg[gi] & bus.vote_yes[gi] & ~bus.vote_no[gi];
    end
  endgenerate

  always_comb begin
    new_yes = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      new_yes = new_yes + CNT_W'(take_yes[i]);
    end
  end

  assign all_voted = &(voted_reg | take_vote);
  assign timer_hit = (timer_reg == TIMER_LAST);
  assign twice_yes = {yes_cnt_reg, 1'b0};

  always_comb begin
    state_next     = state_reg;
    voted_next     = voted_reg;
    yes_cnt_next   = yes_cnt_reg;
    timer_next     = timer_reg;
    timed_out_next = timed_out_reg;
    result_next    = result_reg;
    done_next      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // The cycle carrying the done strobe still belongs to the verdict.
        if (bus.start && !done_reg) begin
          state_next     = OPEN;
          voted_next     = '0;
          yes_cnt_next   = '0;
          timer_next     = '0;
          timed_out_next = 1'b0;
        end
      end
      OPEN: begin
        voted_next   = voted_reg | take_vote;
        yes_cnt_next = yes_cnt_reg + new_yes;
        if (timer_reg != {TIMER_W{1'b1}}) begin
          timer_next = timer_reg + 1'b1;
        end
        timed_out_next = timer_hit && !all_voted && !bus.close;
        if (all_voted || bus.close || timer_hit) begin
          state_next = RESULT;
        end
      end
      RESULT: begin
        state_next = IDLE;
        done_next  = 1'b1;
        if (twice_yes < N_FULL)       result_next = 3'b100;
        else if (twice_yes == N_FULL) result_next = 3'b010;
        else                          result_next = 3'b001;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      voted_reg     <= '0;
      yes_cnt_reg   <= '0;
      timer_reg     <= '0;
      timed_out_reg <= 1'b0;
      result_reg    <= 3'b000;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      voted_reg     <= voted_next;
      yes_cnt_reg   <= yes_cnt_next;
      timer_reg     <= timer_next;
      timed_out_reg <= timed_out_next;
      result_reg    <= result_next;
      done_reg      <= done_next;
    end
  end

  assign bus.busy      = (state_reg != IDLE) || done_reg;
  assign bus.done      = done_reg;
  assign bus.result    = result_reg;
  assign bus.yes_cnt   = yes_cnt_reg;
  assign bus.voted     = voted_reg;
  assign bus.timed_out = timed_out_reg;
endmodule

// File: doc/voter_session.md
# voter_session

Parametrised, sequential successor to the team's 4-input combinational majority voter. Runs a bounded voting session over N_VOTERS independent voters: opens on `start`, latches each voter's first yes/no vote, closes on all-voted, early `close`, or timeout, then publishes a one-hot reject/tie/accept verdict and the yes tally. Sits between the per-voter request logic and the decision consumer that previously read the combinational voter output.

## Interface
- N_VOTERS, 4, number of voters; legal range 2..32.
- TIMEOUT, 255, maximum OPEN-state duration in cycles; legal range 1..2^TIMER_W-1.
- TIMER_W, 8, session timer width.
- CNT_W, $clog2(N_VOTERS+1), tally width.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  open a session; sampled only in IDLE.
- close  in  1  force early close; sampled only in OPEN.
- vote_yes  in  N_VOTERS  per-voter yes strobe.
- vote_no  in  N_VOTERS  per-voter no strobe.
- busy  out  1  session open or verdict in progress.
- done  out  1  one-cycle verdict strobe.
- result  out  3  one-hot verdict: [2] reject, [1] tie, [0] accept.
- yes_cnt  out  CNT_W  yes votes in the last or current session.
- voted  out  N_VOTERS  mask of voters that have voted this session.
- timed_out  out  1  last session closed by timeout.

## Operation
- States: IDLE, OPEN, RESULT. RESULT always returns to IDLE after one cycle.
- IDLE, start=1: next OPEN; clear voted, yes_cnt, timer, timed_out. result holds its previous value.
- OPEN, per voter i with voted[i]=0:
  - vote_yes[i]=1, vote_no[i]=0: set voted[i]; increment yes_cnt.
  - vote_no[i]=1, either value of vote_yes[i]: set voted[i] as a no; a simultaneous yes+no counts as no.
  - Several voters may vote in the same cycle; yes_cnt adds all of them.
- Votes from voters with voted[i]=1 are ignored.
- Votes in IDLE or RESULT are ignored. start is ignored outside IDLE; close is ignored outside OPEN.
- OPEN closes at the current edge when any of the following holds:
  - the post-update voted mask is all ones;
  - close=1;
  - timer==TIMEOUT-1.
  - Votes sampled on the closing edge are counted.
  - timed_out=1 only when the timeout is the sole close cause; all-voted or close takes precedence.
- Non-voters count as no. The verdict uses the full-width compare 2*yes_cnt vs N_VOTERS:
  - less than N_VOTERS: reject, 3'b100;
  - equal: tie, 3'b010 (even N only);
  - greater: accept, 3'b001.
  - For N=4 this matches the legacy table: 0–1 yes → 100, 2 → 010, 3–4 → 001.
- RESULT: register result; done=1 for this cycle only.
- The timer counts cycles in OPEN from 0 and saturates; it never wraps.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=IDLE;
  - busy=0, done=0;
  - result=3'b000 (no verdict yet);
  - yes_cnt=0, voted=0, timed_out=0;
  - timer=0.
- start high at edge k: OPEN and busy=1 from k+1. Votes are accepted from edge k+2 onward (the first OPEN-cycle sample).
- Close at edge m: RESULT during m+1..m+2, so done=1 and result valid after edge m+1. At edge m+2: IDLE, busy=0, done=0.
- Minimum session: start → done is 3 edges (close asserted in the first OPEN cycle).
- Timeout with no votes: OPEN lasts exactly TIMEOUT cycles.
- yes_cnt and voted update at the sampling edge and hold through IDLE until the next start.
- rst_n low mid-session: abort immediately, no done pulse, all outputs at reset values.
- start asserted in the RESULT cycle is ignored; a back-to-back session needs start in IDLE.

## Test plan
- N=4: start; yes on voters 0, 1, 2 in one cycle, no on voter 3 next cycle → all-voted close, result=001, yes_cnt=3, voted=1111, timed_out=0, one done pulse.
- N=4: yes on voters 0 and 1; close next cycle → result=010, yes_cnt=2, voted=0011.
- N=4, TIMEOUT=10: yes on voter 2 only → done 12 edges after start, result=100, yes_cnt=1, timed_out=1.
- Duplicates: voter 1 votes yes, later yes and no together, later yes again; others no → yes_cnt=1. A simultaneous yes+no on a fresh voter counts as no. Votes in IDLE leave yes_cnt unchanged.
- Reset mid-OPEN after 2 votes → busy=0, result=000, voted=0, no done. A following session runs normally.
- N=5: 3 yes then close → 001. 2 yes then timeout → 100, timed_out=1; the tie code never appears.
